shift_rotate_unit: RTL and testbench



---
 rtl/shift_rotate_unit_if.sv | 27 ++
 rtl/shift_rotate_unit.sv | 133 +++++++++++++
 tb/tb_shift_rotate_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_rotate_unit_if.sv
// Purpose: start/busy/done bus between the sample register file and the shift/rotate engine.
// Latency: none, wires only.
// Backpressure: requester holds start; the engine only samples it while idle (busy low).
interface shift_rotate_unit_if #(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH)
);
    logic             start;
    logic [1:0]       op;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, data_in,
        input  result, carry, zero, busy, done
    );

    modport slave (
        input  start, op, amt, data_in,
        output result, carry, zero, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Purpose: multi-cycle rotate right/left and logical/arithmetic right shift, up to STEP positions per clock.
// Latency: done in the cycle after edge accept+ceil(amt/STEP); one operation per ceil(amt/STEP)+2 cycles.
// Backpressure: start is ignored while busy or in the done cycle; inputs are latched on accept only.
module shift_rotate_unit #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_rotate_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_ROR = 2'b00;
    localparam logic [1:0] OP_ROL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // STEP may equal WIDTH, which does not fit in AW bits, so compare one bit wider.
    localparam logic [AW:0] STEP_W = (AW+1)'(STEP);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work, work_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [1:0]       op_q, op_nxt;
    logic             carry_q, carry_nxt;
    logic             busy_q, done_q;

    logic [AW-1:0]    k;
    logic [AW-1:0]    neg_k;
    logic [WIDTH-1:0] stepped;
    logic             out_bit;

    // One step of the latched operation on the work register by k = min(cnt, STEP).
    always_comb begin
        k       = ({1'b0, cnt} > STEP_W) ? STEP_W[AW-1:0] : cnt;
        // WIDTH is a power of two, so -k modulo 2**AW is the complementary rotate distance WIDTH-k.
        neg_k   = -k;
        stepped = work;
        out_bit = 1'b0;
        case (op_q)
            OP_ROR: begin
                stepped = (work >> k) | (work << neg_k);
                out_bit = work[k - 1'b1];
            end
            OP_ROL: begin
                stepped = (work << k) | (work >> neg_k);
                out_bit = work[neg_k];
            end
            OP_SRL: begin
                stepped = work >> k;
                out_bit = work[k - 1'b1];
            end
            OP_SRA: begin
                // The MSB never changes under SRA, so refilling from the current MSB equals the original sign.
                stepped = $signed(work) >>> k;
                out_bit = work[k - 1'b1];
            end
            default: begin
                stepped = work;
                out_bit = 1'b0;
            end
        endcase
    end

    // Next-state and datapath-update logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        carry_nxt = carry_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    work_nxt  = bus.data_in;
                    op_nxt    = bus.op;
                    cnt_nxt   = bus.amt;
                    carry_nxt = 1'b0;
                    state_nxt = (bus.amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_nxt  = stepped;
                carry_nxt = out_bit;
                cnt_nxt   = cnt - k;
                if (cnt == k) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered status flags; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            op_q    <= OP_ROR;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            work    <= work_nxt;
            cnt     <= cnt_nxt;
            op_q    <= op_nxt;
            carry_q <= carry_nxt;
            busy_q  <= (state_nxt != IDLE);
            done_q  <= (state_nxt == DONE);
        end
    end

    assign bus.result = work;
    assign bus.carry  = carry_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.zero   = (work == '0);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Purpose: bench for shift_rotate_unit with four instances (STEP 1, 3, 4, 16) sharing one stimulus.
// Latency: expected done cycle is ceil(amt/STEP) negedges after the accepting edge.
// Backpressure: start is driven only when all instances are idle, except in the held-start sequence.
module tb_shift_rotate_unit;

    localparam int W = 16;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         start = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [3:0]   amt = 4'd0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] res [NDUT];
    logic         car [NDUT];
    logic         zr  [NDUT];
    logic         bsy [NDUT];
    logic         dn  [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int step_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 16;
    endfunction

    generate
        for (genvar g = 0; g < NDUT; g++) begin : gen_dut
            shift_rotate_unit_if #(.WIDTH(W)) bus ();
            assign bus.start   = start;
            assign bus.op      = op;
            assign bus.amt     = amt;
            assign bus.data_in = data_in;
            assign res[g] = bus.result;
            assign car[g] = bus.carry;
            assign zr[g]  = bus.zero;
            assign bsy[g] = bus.busy;
            assign dn[g]  = bus.done;
            shift_rotate_unit #(.WIDTH(W), .STEP(step_of(g))) dut (
                .clk   (clk),
                .rst_n (rst_n),
                .bus   (bus)
            );
        end
    endgenerate

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d(step %0d): got %0h expected %0h", name, g, step_of(g), act, exp);
        end
    endtask

    // Whole-amount reference: rotate/shift computed in one go from the arithmetic rules. Returns {carry, result}.
    function automatic logic [W:0] model(input logic [1:0] o, input int a, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic         c;
        if (a == 0) return {1'b0, d};
        case (o)
            2'd0: begin r = (d >> a) | (d << (W - a)); c = d[a-1]; end
            2'd1: begin r = (d << a) | (d >> (W - a)); c = d[W-a]; end
            2'd2: begin r = d >> a;                    c = d[a-1]; end
            default: begin r = W'($signed(d) >>> a);   c = d[a-1]; end
        endcase
        return {c, r};
    endfunction

    // Issue one operation from a negedge with all instances idle; inputs are scrambled while busy.
    task automatic run_op(input logic [1:0] o, input logic [3:0] a, input logic [W-1:0] d,
                          input logic [W-1:0] er, input logic ec);
        int done_c [NDUT];
        int done_n [NDUT];
        int busy_n [NDUT];
        logic [W-1:0] r_at [NDUT];
        logic c_at [NDUT];
        logic z_at [NDUT];
        for (int g = 0; g < NDUT; g++) begin
            done_c[g] = -1; done_n[g] = 0; busy_n[g] = 0;
            r_at[g] = '0; c_at[g] = 1'b0; z_at[g] = 1'b0;
        end
        op = o; amt = a; data_in = d; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= int'(a) + 2; c++) begin
            if (c > 0) @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (c == 0) check("result_during_busy", g, 32'(res[g]), 32'(d));
                if (bsy[g]) busy_n[g]++;
                if (dn[g]) begin
                    done_n[g]++;
                    if (done_c[g] < 0) begin
                        done_c[g] = c;
                        r_at[g] = res[g];
                        c_at[g] = car[g];
                        z_at[g] = zr[g];
                    end
                end
            end
            op = 2'($urandom_range(0, 3));
            amt = 4'($urandom_range(0, 15));
            data_in = W'($urandom);
        end
        for (int g = 0; g < NDUT; g++) begin
            int n;
            n = (int'(a) + step_of(g) - 1) / step_of(g);
            check("done_cycle", g, 32'(done_c[g]), 32'(n));
            check("done_pulses", g, 32'(done_n[g]), 32'd1);
            check("busy_cycles", g, 32'(busy_n[g]), 32'(n + 1));
            check("result", g, 32'(r_at[g]), 32'(er));
            check("carry", g, 32'(c_at[g]), 32'(ec));
            check("zero", g, 32'(z_at[g]), 32'(er == '0));
        end
    endtask

    typedef struct {
        logic [1:0]   o;
        logic [3:0]   a;
        logic [W-1:0] d;
        logic [W-1:0] er;
        logic         ec;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int dones;
        int first_done;
        int second_done;
        logic [W:0] m;

        vecs[0] = '{2'd0, 4'd1,  16'h0001, 16'h8000, 1'b1};
        vecs[1] = '{2'd0, 4'd1,  16'hABCD, 16'hD5E6, 1'b1};
        vecs[2] = '{2'd1, 4'd7,  16'h8001, 16'h00C0, 1'b0};
        vecs[3] = '{2'd0, 4'd0,  16'h1234, 16'h1234, 1'b0};
        vecs[4] = '{2'd3, 4'd15, 16'h8000, 16'hFFFF, 1'b0};
        vecs[5] = '{2'd2, 4'd15, 16'h8000, 16'h0001, 1'b0};
        vecs[6] = '{2'd2, 4'd4,  16'h000F, 16'h0000, 1'b1};
        vecs[7] = '{2'd3, 4'd4,  16'hF0F0, 16'hFF0F, 1'b0};
        vecs[8] = '{2'd1, 4'd1,  16'h8000, 16'h0001, 1'b1};
        vecs[9] = '{2'd0, 4'd8,  16'h12F0, 16'hF012, 1'b1};

        // Power-on reset state.
        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < NDUT; g++) begin
            check("rst_result", g, 32'(res[g]), 32'h0);
            check("rst_busy", g, 32'(bsy[g]), 32'h0);
            check("rst_done", g, 32'(dn[g]), 32'h0);
            check("rst_zero", g, 32'(zr[g]), 32'h1);
            check("rst_carry", g, 32'(car[g]), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, first one accepted on the first edge after reset release.
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].d, vecs[i].er, vecs[i].ec);
        end

        // Reset in the middle of a STEP=1 ROR by 9.
        op = 2'd0; amt = 4'd9; data_in = 16'hABCD; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_reset", 0, 32'(bsy[0]), 32'h1);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check("midop_rst_result", g, 32'(res[g]), 32'h0);
            check("midop_rst_busy", g, 32'(bsy[g]), 32'h0);
            check("midop_rst_done", g, 32'(dn[g]), 32'h0);
            check("midop_rst_zero", g, 32'(zr[g]), 32'h1);
            check("midop_rst_carry", g, 32'(car[g]), 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) if (dn[g] || bsy[g]) dones++;
        end
        check("no_activity_after_reset", 0, 32'(dones), 32'h0);

        // start held high: STEP=1 ROR by 3 re-accepts at accept+N+2.
        op = 2'd0; amt = 4'd3; data_in = 16'h00F0; start = 1'b1;
        first_done = -1; second_done = -1;
        @(posedge clk);
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (dn[0]) begin
                if (first_done < 0) begin
                    first_done = c;
                    check("held_start_result1", 0, 32'(res[0]), 32'h001E);
                end else if (second_done < 0) begin
                    second_done = c;
                    check("held_start_result2", 0, 32'(res[0]), 32'h001E);
                end
            end
        end
        check("held_start_done1", 0, 32'(first_done), 32'd3);
        check("held_start_done2", 0, 32'(second_done), 32'd8);
        start = 1'b0;
        repeat (20) @(negedge clk);

        // Randomised operations against the whole-amount model.
        for (int i = 0; i < 2000; i++) begin
            logic [1:0]   ro;
            logic [3:0]   ra;
            logic [W-1:0] rd;
            ro = 2'($urandom_range(0, 3));
            ra = 4'($urandom_range(0, 15));
            rd = W'($urandom);
            m = model(ro, int'(ra), rd);
            run_op(ro, ra, rd, m[W-1:0], m[W]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
